dcache_fc: RTL and testbench
============================

DCACHE_FC -- requirements
Module: dcache_fc

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, cycles allowed in FC_REQ+FC_WAIT before abort (used only with FC_TIMEOUT_EN).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous assert, active-high.
REQ-004 Port: mem_req_i  in  1  memory access pending from pipeline (level, held until accepted).
REQ-005 Port: mem_we_i  in  1  1 = store, 0 = load; qualified by mem_req_i.
REQ-006 Port: mem_addr_i  in  32  access address.
REQ-007 Port: Dcache_req_o  out  1  request to Dcache.
REQ-008 Port: Dcache_we_o  out  1  store flag to Dcache.
REQ-009 Port: Dcache_addr_o  out  32  address to Dcache.
REQ-010 Port: Dcache_gnt_i  in  1  Dcache accepted request this cycle.
REQ-011 Port: Dcache_rvalid_i  in  1  Dcache load data valid this cycle.
REQ-012 Port: fc_stall_o  out  1  freeze pipeline registers up to and including mem_wb_reg.
REQ-013 Port: fc_Dcache_data_valid_o  out  1  load data valid to WB stage (gates register write).
REQ-014 Port: fc_err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 States SHALL be FC_IDLE, FC_REQ, FC_WAIT; state, latched address and latched we are registers, all outputs are decoded from state and current inputs.
REQ-016 FC_IDLE: Dcache_req_o = mem_req_i, Dcache_addr_o/Dcache_we_o = mem_addr_i/mem_we_i (pass-through).
REQ-017 FC_IDLE, mem_req_i=1: gnt=1 & store -> FC_IDLE, stall 0; gnt=1 & load -> FC_WAIT, stall 1; gnt=0 -> latch addr/we, FC_REQ, stall 1.
REQ-018 FC_REQ: Dcache_req_o = 1 with latched addr/we; stall 1; on gnt: store -> FC_IDLE (stall 0 that cycle), load -> FC_WAIT.
REQ-019 FC_WAIT: Dcache_req_o = 0; fc_Dcache_data_valid_o = Dcache_rvalid_i; fc_stall_o = !Dcache_rvalid_i; rvalid -> FC_IDLE.
REQ-020 Minimum load latency: req+gnt cycle 0, rvalid cycle 1 -> stall 1 in cycle 0, stall 0 and data_valid 1 in cycle 1.
REQ-021 Store with immediate gnt SHALL cost zero stall cycles.
REQ-022 Back-to-back: mem_req_i in the cycle that completes a load in FC_WAIT is NOT issued; it is issued from FC_IDLE next cycle (one bubble).
REQ-023 Dcache_rvalid_i in FC_IDLE or FC_REQ SHALL be ignored: no data_valid, no state change.
REQ-024 fc_Dcache_data_valid_o SHALL never be 1 outside FC_WAIT; fc_err_o 0 unless FC_TIMEOUT_EN.

Reset
REQ-025 rst=1 SHALL asynchronously force FC_IDLE, latched addr 0, latched we 0, timeout count 0.
REQ-026 While in reset: Dcache_req_o, fc_stall_o, fc_Dcache_data_valid_o, fc_err_o = 0.
REQ-027 Reset mid-transaction abandons it; a late rvalid after reset is ignored per REQ-023.

Configuration
REQ-028 Macro FC_TIMEOUT_EN defined: 8-bit counter clears on entering FC_REQ/FC_WAIT, increments each cycle there; reaching TIMEOUT_CYCLES with no gnt/rvalid -> FC_IDLE, fc_err_o pulse 1 cycle, stall 0, data_valid 0, Dcache_req_o 0 that cycle.
REQ-029 Macro undefined: no counter, fc_err_o tied 0, FC_REQ/FC_WAIT wait indefinitely.

Structure
REQ-030 Package fc_pkg SHALL hold the state typedef (FC_IDLE/FC_REQ/FC_WAIT) and the address width constant (32).
REQ-031 Sub-module fc_timeout_cnt (clear, enable, expired) SHALL hold the counter, instantiated only under FC_TIMEOUT_EN.

Verification
REQ-032 Load, gnt cycle 0, rvalid cycle 1, addr 0x1000 -> Dcache_addr_o 0x1000, stall 1,0; data_valid 0,1.
REQ-033 Store, gnt withheld 3 cycles, addr 0x2004 -> stall 1 for 3 cycles, Dcache_addr_o held 0x2004, stall 0 on gnt cycle.
REQ-034 Load completes with mem_req_i held for second load -> second Dcache_req_o issued one cycle after data_valid.
REQ-035 Spurious rvalid in FC_IDLE -> data_valid 0, state FC_IDLE; rst asserted in FC_WAIT -> all outputs 0 immediately.
REQ-036 FC_TIMEOUT_EN, TIMEOUT_CYCLES=4, load granted, no rvalid -> fc_err_o pulse after 4 FC_WAIT cycles, FC_IDLE, data_valid never 1.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the Dcache flow controller.
package fc_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_WAIT = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fc_timeout_cnt.sv
// Wait-cycle counter for the flow controller; only built when FC_TIMEOUT_EN is defined.
module fc_timeout_cnt #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] r_cnt;

  assign expired_o = (r_cnt == LIMIT);

  // Saturates at LIMIT so an expiry cannot wrap back to an early count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (clear_i) begin
      r_cnt <= 8'd0;
    end else if (en_i && !expired_o) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dcache_fc.sv
// Dcache flow controller: issues pipeline loads/stores to the Dcache and stalls until done.
// Optional abort on stuck transactions is enabled with the FC_TIMEOUT_EN macro.
module dcache_fc
  import fc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              Dcache_req_o,
  output logic              Dcache_we_o,
  output logic [ADDR_W-1:0] Dcache_addr_o,
  input  logic              Dcache_gnt_i,
  input  logic              Dcache_rvalid_i,
  output logic              fc_stall_o,
  output logic              fc_Dcache_data_valid_o,
  output logic              fc_err_o
);

  fc_state_e         r_state;
  fc_state_e         w_state_n;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              w_tmo;
  logic              w_req;
  logic              w_stall;
  logic              w_dv;
  logic              w_err;

`ifdef FC_TIMEOUT_EN
  logic w_cnt_clr;
  logic w_cnt_en;

  // Any state change restarts the count, so REQ->WAIT gets a fresh budget.
  assign w_cnt_clr = (w_state_n != r_state);
  assign w_cnt_en  = (r_state != FC_IDLE);

  fc_timeout_cnt #(
    .LIMIT (8'(TIMEOUT_CYCLES))
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_cnt_clr),
    .en_i      (w_cnt_en),
    .expired_o (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FC_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == FC_IDLE && mem_req_i && !Dcache_gnt_i) begin
        r_addr <= mem_addr_i;
        r_we   <= mem_we_i;
      end
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_req         = 1'b0;
    Dcache_we_o   = r_we;
    Dcache_addr_o = r_addr;
    w_stall       = 1'b0;
    w_dv          = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      FC_IDLE: begin
        w_req         = mem_req_i;
        Dcache_we_o   = mem_we_i;
        Dcache_addr_o = mem_addr_i;
        if (mem_req_i) begin
          if (Dcache_gnt_i) begin
            // A granted store retires immediately; a granted load waits for data.
            w_stall = !mem_we_i;
            if (!mem_we_i) w_state_n = FC_WAIT;
          end else begin
            w_stall   = 1'b1;
            w_state_n = FC_REQ;
          end
        end
      end
      FC_REQ: begin
        if (Dcache_gnt_i) begin
          w_req     = 1'b1;
          w_stall   = !r_we;
          w_state_n = r_we ? FC_IDLE : FC_WAIT;
        end else if (w_tmo) begin
          w_err     = 1'b1;
          w_state_n = FC_IDLE;
        end else begin
          w_req   = 1'b1;
          w_stall = 1'b1;
        end
      end
      FC_WAIT: begin
        if (Dcache_rvalid_i) begin
          w_dv      = 1'b1;
          w_state_n = FC_IDLE;
        end else if (w_tmo) begin
          w_err     = 1'b1;
          w_state_n = FC_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_n = FC_IDLE;
    endcase
  end

  // IDLE passes the request through combinationally, so reset must mask it explicitly.
  assign Dcache_req_o           = w_req   && !rst;
  assign fc_stall_o             = w_stall && !rst;
  assign fc_Dcache_data_valid_o = w_dv    && !rst;
  assign fc_err_o               = w_err   && !rst;

endmodule

// File: tb/tb_dcache_fc.sv
// Directed bench for dcache_fc; define FC_TIMEOUT_EN to also exercise the abort path.
module tb_dcache_fc;
  import fc_pkg::*;

  logic              clk;
  logic              rst;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              Dcache_req_o;
  logic              Dcache_we_o;
  logic [ADDR_W-1:0] Dcache_addr_o;
  logic              Dcache_gnt_i;
  logic              Dcache_rvalid_i;
  logic              fc_stall_o;
  logic              fc_Dcache_data_valid_o;
  logic              fc_err_o;

  int checks;
  int errors;

  dcache_fc #(.TIMEOUT_CYCLES(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_i              (mem_req_i),
    .mem_we_i               (mem_we_i),
    .mem_addr_i             (mem_addr_i),
    .Dcache_req_o           (Dcache_req_o),
    .Dcache_we_o            (Dcache_we_o),
    .Dcache_addr_o          (Dcache_addr_o),
    .Dcache_gnt_i           (Dcache_gnt_i),
    .Dcache_rvalid_i        (Dcache_rvalid_i),
    .fc_stall_o             (fc_stall_o),
    .fc_Dcache_data_valid_o (fc_Dcache_data_valid_o),
    .fc_err_o               (fc_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, then apply inputs for that cycle.
  task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                     input logic gnt, input logic rv);
    @(posedge clk);
    #1;
    mem_req_i       = req;
    mem_we_i        = we;
    mem_addr_i      = addr;
    Dcache_gnt_i    = gnt;
    Dcache_rvalid_i = rv;
    #3;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic stall,
                         input logic dv, input logic err);
    chk({tag, ".req"},   {31'd0, Dcache_req_o},           {31'd0, req});
    chk({tag, ".stall"}, {31'd0, fc_stall_o},             {31'd0, stall});
    chk({tag, ".dv"},    {31'd0, fc_Dcache_data_valid_o}, {31'd0, dv});
    chk({tag, ".err"},   {31'd0, fc_err_o},               {31'd0, err});
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    mem_req_i       = 1'b1;
    mem_we_i        = 1'b0;
    mem_addr_i      = 32'h0000_0abc;
    Dcache_gnt_i    = 1'b0;
    Dcache_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    mem_req_i = 1'b0;

    // Minimum-latency load at 0x1000.
    cyc(1'b1, 1'b0, 32'h1000, 1'b1, 1'b0);
    chk_out("ld0", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ld0.addr", Dcache_addr_o, 32'h1000);
    chk("ld0.we", {31'd0, Dcache_we_o}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("ld1", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("ld2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Store at 0x2004 with grant withheld for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'h2004, 1'b0, 1'b0);
      chk_out($sformatf("stw%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("stw%0d.addr", i), Dcache_addr_o, 32'h2004);
      chk($sformatf("stw%0d.we", i), {31'd0, Dcache_we_o}, 32'd1);
    end
    cyc(1'b1, 1'b1, 32'h2004, 1'b1, 1'b0);
    chk_out("stg", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stg.addr", Dcache_addr_o, 32'h2004);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("sti", 1'b0, 1'b0, 1'b0, 1'b0);

    // Store granted immediately costs no stall.
    cyc(1'b1, 1'b1, 32'h2008, 1'b1, 1'b0);
    chk_out("st0", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("st0i", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back loads: the second one issues one cycle after data_valid.
    cyc(1'b1, 1'b0, 32'h3000, 1'b1, 1'b0);
    chk_out("bb0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h3040, 1'b1, 1'b1);
    chk_out("bb1", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h3040, 1'b1, 1'b0);
    chk_out("bb2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bb2.addr", Dcache_addr_o, 32'h3040);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("bb3", 1'b0, 1'b0, 1'b1, 1'b0);

    // Spurious rvalid in IDLE, then confirm the FSM is still in IDLE.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("spi", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h4000, 1'b1, 1'b0);
    chk_out("spi2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("spi2.addr", Dcache_addr_o, 32'h4000);

    // Spurious rvalid in REQ, then reset while in WAIT.
    cyc(1'b1, 1'b0, 32'h5000, 1'b0, 1'b0);
    chk_out("spr0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h5000, 1'b0, 1'b1);
    chk_out("spr1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("spr1.addr", Dcache_addr_o, 32'h5000);
    cyc(1'b1, 1'b0, 32'h5000, 1'b1, 1'b0);
    chk_out("spr2", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("wt", 1'b0, 1'b1, 1'b0, 1'b0);
    Dcache_rvalid_i = 1'b1;
    rst             = 1'b1;
    #1;
    chk_out("rstw", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("late", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FC_TIMEOUT_EN
    // Granted load with no rvalid aborts after four WAIT cycles.
    cyc(1'b1, 1'b0, 32'h6000, 1'b1, 1'b0);
    chk_out("to0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_out($sformatf("tow%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("toe", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("toi", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
